// File: rtl/qei_pkg.sv
// Shared definitions for the quadrature encoder front end.
// Latency: n/a (constants, types and a pure decode function).
// Backpressure: n/a.
package qei_pkg;

    // Quadrature states as {A,B}; the up direction walks S00->S01->S11->S10->S00.
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    localparam int DEF_CNT_W    = 32;
    localparam int DEF_FILT_LEN = 4;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } dec_t;

    // 4x decode of one accepted {A,B} sample against the previous one.
    function automatic dec_t qei_decode(input logic [1:0] prev, input logic [1:0] cur);
        dec_t res;
        res = NONE;
        if (prev == cur) begin
            res = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            res = ILLEGAL;
        end else if ((prev == S00 && cur == S01) || (prev == S01 && cur == S11) ||
                     (prev == S11 && cur == S10) || (prev == S10 && cur == S00)) begin
            res = UP;
        end else begin
            res = DOWN;
        end
        return res;
    endfunction

endpackage

// File: rtl/qei_decoder_if.sv
// Bundle of encoder pads, control strobes and decoder results.
// Latency: n/a (wiring only); slave = decoder, master = its controller/pads.
// Backpressure: none; all results are level registers or one-cycle pulses.
interface qei_decoder_if #(
    parameter int CNT_W = qei_pkg::DEF_CNT_W
);
    logic             qei_a;
    logic             qei_b;
    logic             qei_i;
    logic             enable;
    logic             dir_invert;
    logic             pos_load;
    logic [CNT_W-1:0] pos_load_val;
    logic             idx_clr_en;
    logic             err_clr;
    logic [CNT_W-1:0] position;
    logic [CNT_W-1:0] idx_position;
    logic             idx_event;
    logic             step_event;
    logic             dir;
    logic             err;
`ifdef QEI_VELOCITY_EN
    logic signed [15:0] velocity;
`endif

    modport master (
        output qei_a, qei_b, qei_i, enable, dir_invert, pos_load, pos_load_val,
               idx_clr_en, err_clr,
`ifdef QEI_VELOCITY_EN
        input  velocity,
`endif
        input  position, idx_position, idx_event, step_event, dir, err
    );

    modport slave (
        input  qei_a, qei_b, qei_i, enable, dir_invert, pos_load, pos_load_val,
               idx_clr_en, err_clr,
`ifdef QEI_VELOCITY_EN
        output velocity,
`endif
        output position, idx_position, idx_event, step_event, dir, err
    );

endinterface

// File: rtl/qei_filter.sv
// Two-flop synchronizer plus debounce for one asynchronous encoder pad.
// Latency: pad change to o_level change is 2 + FILT_LEN sys_clk cycles.
// Backpressure: none; glitches shorter than FILT_LEN synchronized cycles vanish.
// Ports: sys_clk, sys_rst_n (async active-low), i_pad (raw pad), o_level (accepted level).
module qei_filter
    import qei_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_pad,
    output logic o_level
);

    localparam int             CW   = $clog2(FILT_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            // Count consecutive samples disagreeing with the accepted level;
            // any agreeing sample restarts the qualification window.
            if (r_sync2 != r_level) begin
                if (r_cnt == LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder front end: filtered 4x decode into a signed position counter with index capture.
// Latency: pad edge to position/step_event update is 2 + FILT_LEN + 1 cycles.
// Backpressure: none; pos_load/err_clr are one-cycle strobes. Optional QEI_VELOCITY_EN adds velocity output.
// Ports: sys_clk, sys_rst_n (async active-low), bus (qei_decoder_if.slave: pads, controls, results).
// bus CNT_W must equal this module's CNT_W.
module qei_decoder
    import qei_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int FILT_LEN = DEF_FILT_LEN
`ifdef QEI_VELOCITY_EN
    , parameter int VEL_PERIOD = 1000
`endif
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    qei_decoder_if.slave  bus
);

    logic w_a;
    logic w_b;
    logic w_i;

    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_pad     (bus.qei_a),
        .o_level   (w_a)
    );

    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_pad     (bus.qei_b),
        .o_level   (w_b)
    );

    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_pad     (bus.qei_i),
        .o_level   (w_i)
    );

    logic [1:0]       r_prev_ab;
    logic             r_prev_i;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_idx_pos;
    logic             r_idx_evt;
    logic             r_step_evt;
    logic             r_dir;
    logic             r_err;

    dec_t             w_dec;
    logic             w_up;
    logic             w_dn;
    logic             w_count;
    logic             w_idx_hit;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_pos_next;

    assign w_dec = qei_decode(r_prev_ab, {w_a, w_b});

    // Direction after optional inversion; dir reports this, not the raw decode.
    assign w_up      = bus.dir_invert ? (w_dec == DOWN) : (w_dec == UP);
    assign w_dn      = bus.dir_invert ? (w_dec == UP)   : (w_dec == DOWN);
    assign w_count   = bus.enable & (w_up | w_dn);
    assign w_idx_hit = bus.enable & w_i & ~r_prev_i;

    // Count result alone; this is also what the index capture latches.
    assign w_cnt_val = w_count ? (w_up ? r_pos + CNT_W'(1) : r_pos - CNT_W'(1)) : r_pos;

    // Position priority: load over index clear over count.
    always_comb begin
        w_pos_next = w_cnt_val;
        if (w_idx_hit && bus.idx_clr_en) begin
            w_pos_next = '0;
        end
        if (bus.pos_load) begin
            w_pos_next = bus.pos_load_val;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_prev_ab  <= S00;
            r_prev_i   <= 1'b0;
            r_pos      <= '0;
            r_idx_pos  <= '0;
            r_idx_evt  <= 1'b0;
            r_step_evt <= 1'b0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Previous-state regs track even while disabled so re-enabling
            // does not produce a spurious step.
            r_prev_ab  <= {w_a, w_b};
            r_prev_i   <= w_i;
            r_pos      <= w_pos_next;
            r_idx_evt  <= w_idx_hit;
            r_step_evt <= w_count;
            if (w_idx_hit) begin
                r_idx_pos <= w_cnt_val;
            end
            if (w_count) begin
                r_dir <= w_up;
            end
            // A new illegal transition beats a simultaneous clear.
            r_err <= (w_dec == ILLEGAL) | (r_err & ~bus.err_clr);
        end
    end

    assign bus.position     = r_pos;
    assign bus.idx_position = r_idx_pos;
    assign bus.idx_event    = r_idx_evt;
    assign bus.step_event   = r_step_evt;
    assign bus.dir          = r_dir;
    assign bus.err          = r_err;

`ifdef QEI_VELOCITY_EN
    // Net signed steps per VEL_PERIOD window, saturated to +/-32767.
    logic [31:0]        r_vel_tick;
    logic signed [31:0] r_vel_acc;
    logic signed [15:0] r_velocity;
    logic signed [31:0] w_delta;
    logic signed [31:0] w_acc_sum;
    logic signed [15:0] w_vel_sat;

    assign w_delta   = w_count ? (w_up ? 32'sd1 : -32'sd1) : 32'sd0;
    assign w_acc_sum = r_vel_acc + w_delta;

    always_comb begin
        w_vel_sat = w_acc_sum[15:0];
        if (w_acc_sum > 32'sd32767) begin
            w_vel_sat = 16'sd32767;
        end else if (w_acc_sum < -32'sd32767) begin
            w_vel_sat = -16'sd32767;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vel_tick <= '0;
            r_vel_acc  <= '0;
            r_velocity <= '0;
        end else if (r_vel_tick == 32'(VEL_PERIOD - 1)) begin
            r_vel_tick <= '0;
            r_vel_acc  <= '0;
            r_velocity <= w_vel_sat;
        end else begin
            r_vel_tick <= r_vel_tick + 32'd1;
            r_vel_acc  <= w_acc_sum;
        end
    end

    assign bus.velocity = r_velocity;
`endif

endmodule

// File: tb/tb_qei_decoder.sv
// Directed bench for qei_decoder: encoder pad sequences against a bench-side position model.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_qei_decoder;

    localparam int HOLD = 8;   // FILT_LEN + 4 cycles per quadrature level

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    qei_decoder_if #(.CNT_W(32)) bus ();

    qei_decoder #(.CNT_W(32), .FILT_LEN(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    int          n_vec   = 0;
    int          n_err   = 0;
    int          n_steps = 0;
    int          n_idx   = 0;
    int          s0;
    logic [31:0] exp_q[$];
    logic [1:0]  ab;
    logic [31:0] mpos;

    // Pulse counters sampled mid-cycle.
    always @(negedge sys_clk) if (bus.step_event === 1'b1) n_steps++;
    always @(negedge sys_clk) if (bus.idx_event === 1'b1) n_idx++;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    function automatic logic [1:0] gray(input logic [1:0] s, input logic up);
        logic [1:0] n;
        case (s)
            2'b00:   n = up ? 2'b01 : 2'b10;
            2'b01:   n = up ? 2'b11 : 2'b00;
            2'b11:   n = up ? 2'b10 : 2'b01;
            default: n = up ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        ab = v;
        bus.qei_a = v[1];
        bus.qei_b = v[0];
    endtask

    task automatic step(input logic up);
        drive_ab(gray(ab, up));
        tick(HOLD);
    endtask

    task automatic load(input logic [31:0] v);
        bus.pos_load_val = v;
        bus.pos_load     = 1'b1;
        tick(1);
        bus.pos_load     = 1'b0;
        mpos             = v;
    endtask

    initial begin
        sys_rst_n        = 1'b0;
        bus.qei_a        = 1'b0;
        bus.qei_b        = 1'b0;
        bus.qei_i        = 1'b0;
        bus.enable       = 1'b0;
        bus.dir_invert   = 1'b0;
        bus.pos_load     = 1'b0;
        bus.pos_load_val = '0;
        bus.idx_clr_en   = 1'b0;
        bus.err_clr      = 1'b0;
        ab   = 2'b00;
        mpos = '0;
        tick(3);

        // Reset state
        push(0); chk("rst_position",   bus.position);
        push(0); chk("rst_idx_pos",    bus.idx_position);
        push(0); chk("rst_idx_event",  32'(bus.idx_event));
        push(0); chk("rst_step_event", 32'(bus.step_event));
        push(0); chk("rst_dir",        32'(bus.dir));
        push(0); chk("rst_err",        32'(bus.err));
        sys_rst_n = 1'b1;
        tick(2);
        bus.enable = 1'b1;

        // Clean 4x up: 32 edges
        s0 = n_steps;
        for (int k = 0; k < 32; k++) begin
            step(1'b1);
            mpos = mpos + 32'd1;
        end
        push(mpos);  chk("up_position", bus.position);
        push(1);     chk("up_dir",      32'(bus.dir));
        push(32);    chk("up_steps",    32'(n_steps - s0));
        push(0);     chk("up_err",      32'(bus.err));

        // Same sequence with direction inverted, from zero
        load(32'd0);
        bus.dir_invert = 1'b1;
        s0 = n_steps;
        for (int k = 0; k < 32; k++) begin
            step(1'b1);
            mpos = mpos - 32'd1;
        end
        push(32'hFFFF_FFE0); chk("inv_position", bus.position);
        push(0);             chk("inv_dir",      32'(bus.dir));
        push(32);            chk("inv_steps",    32'(n_steps - s0));
        bus.dir_invert = 1'b0;

        // Two-cycle glitch on A is rejected
        s0 = n_steps;
        bus.qei_a = 1'b1;
        tick(2);
        bus.qei_a = 1'b0;
        tick(12);
        push(mpos); chk("glitch_position", bus.position);
        push(0);    chk("glitch_steps",    32'(n_steps - s0));

        // Real A edge (00->10, down): count lands 7 cycles after the pad edge
        drive_ab(2'b10);
        tick(6);
        push(mpos); chk("latency_early", bus.position);
        tick(1);
        mpos = mpos - 32'd1;
        push(mpos); chk("latency_exact", bus.position);
        tick(HOLD);
        step(1'b1);                 // 10 -> 00
        mpos = mpos + 32'd1;

        // Illegal 00 -> 11
        drive_ab(2'b11);
        tick(HOLD);
        push(1);    chk("illegal_err",      32'(bus.err));
        push(mpos); chk("illegal_position", bus.position);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        push(0);    chk("err_cleared", 32'(bus.err));

        // Illegal 11 -> 00 decoded in the same cycle as err_clr
        drive_ab(2'b00);
        tick(6);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;
        push(1);    chk("err_set_wins", 32'(bus.err));
        tick(2);
        bus.err_clr = 1'b1;
        tick(1);
        bus.err_clr = 1'b0;

        // Disabled: no counting, but illegal transitions still flag
        bus.enable = 1'b0;
        s0 = n_steps;
        step(1'b1);                 // 00 -> 01
        push(mpos); chk("dis_position", bus.position);
        push(0);    chk("dis_steps",    32'(n_steps - s0));
        drive_ab(2'b10);            // 01 -> 10 illegal
        tick(HOLD);
        push(1);    chk("dis_err", 32'(bus.err));
        step(1'b1);                 // 10 -> 00
        bus.enable = 1'b1;

        // Index capture without clear
        load(32'd100);
        s0 = n_idx;
        bus.qei_i = 1'b1;
        tick(HOLD);
        push(100); chk("idx_capture",  bus.idx_position);
        push(1);   chk("idx_pulses",   32'(n_idx - s0));
        push(mpos); chk("idx_position", bus.position);
        bus.qei_i = 1'b0;
        tick(HOLD);

        // Index capture with clear
        bus.idx_clr_en = 1'b1;
        s0 = n_idx;
        bus.qei_i = 1'b1;
        tick(HOLD);
        mpos = 32'd0;
        push(mpos); chk("idxclr_position", bus.position);
        push(100);  chk("idxclr_capture",  bus.idx_position);
        push(1);    chk("idxclr_pulses",   32'(n_idx - s0));
        bus.qei_i = 1'b0;
        tick(HOLD);
        bus.idx_clr_en = 1'b0;

        // Wrap through the signed maximum
        load(32'h7FFF_FFFF);
        step(1'b1);                 // 00 -> 01
        mpos = 32'h8000_0000;
        push(mpos); chk("wrap_position", bus.position);

        // Load coincident with a count: load wins, step still pulses
        s0 = n_steps;
        drive_ab(gray(ab, 1'b1));   // 01 -> 11
        tick(6);
        load(32'h0000_1234);
        tick(HOLD);
        push(mpos); chk("loadwin_position", bus.position);
        push(1);    chk("loadwin_steps",    32'(n_steps - s0));

        // Reset mid-motion clears outputs immediately
        drive_ab(2'b10);
        tick(3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        push(0); chk("midrst_position", bus.position);
        push(0); chk("midrst_idx_pos",  bus.idx_position);
        push(0); chk("midrst_dir",      32'(bus.dir));
        push(0); chk("midrst_err",      32'(bus.err));
        tick(2);
        sys_rst_n = 1'b1;

        // After release, pads at 10 are judged against 00: one legal down step
        tick(HOLD + 2);
        push(32'hFFFF_FFFF); chk("postrst_position", bus.position);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
